ppc_bus_master: RTL and testbench

PPC_BUS_MASTER -- requirements
Module: ppc_bus_master

---
 rtl/ppc_bus_master_if.sv | 54 +++++
 rtl/ppc_bus_master.sv | 217 +++++++++++++++++++++
 tb/tb_ppc_bus_master.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppc_bus_master_if.sv
// Host-side handshake and bus control signals of the PowerPC 60x-style bus master.
// master modport: the bus master block. slave modport: host plus bus target/arbiter.
//   Host request : REQ_VALID/REQ_READY, REQ_ADDR, REQ_WRITE/BURST/CI/WT/GBL
//   Write data   : WDATA in, WD_ACK out (one pulse per consumed beat)
//   Read data    : RDATA/RD_VALID out
//   Completion   : DONE/ERR out
//   Bus control  : BR_N, TS_N, TBST_N, CI, WT, GBL out; BG_N, AACK_N, ARTRY_N, DBG_N, TA_N,
//                  TEA_N in (all active-low except CI/WT/GBL)
// The tristate bus pins (A, TT, TSIZ, D) are plain ports of the master module.
interface ppc_bus_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);
  logic              REQ_VALID;
  logic              REQ_READY;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic              REQ_WRITE;
  logic              REQ_BURST;
  logic              REQ_CI;
  logic              REQ_WT;
  logic              REQ_GBL;
  logic [DATA_W-1:0] WDATA;
  logic              WD_ACK;
  logic [DATA_W-1:0] RDATA;
  logic              RD_VALID;
  logic              DONE;
  logic              ERR;
  logic              BR_N;
  logic              TS_N;
  logic              TBST_N;
  logic              CI;
  logic              WT;
  logic              GBL;
  logic              BG_N;
  logic              AACK_N;
  logic              ARTRY_N;
  logic              DBG_N;
  logic              TA_N;
  logic              TEA_N;

  modport master (
    input  REQ_VALID, REQ_ADDR, REQ_WRITE, REQ_BURST, REQ_CI, REQ_WT, REQ_GBL, WDATA,
    input  BG_N, AACK_N, ARTRY_N, DBG_N, TA_N, TEA_N,
    output REQ_READY, WD_ACK, RDATA, RD_VALID, DONE, ERR,
    output BR_N, TS_N, TBST_N, CI, WT, GBL
  );

  modport slave (
    output REQ_VALID, REQ_ADDR, REQ_WRITE, REQ_BURST, REQ_CI, REQ_WT, REQ_GBL, WDATA,
    output BG_N, AACK_N, ARTRY_N, DBG_N, TA_N, TEA_N,
    input  REQ_READY, WD_ACK, RDATA, RD_VALID, DONE, ERR,
    input  BR_N, TS_N, TBST_N, CI, WT, GBL
  );
endinterface

// File: rtl/ppc_bus_master.sv
// PowerPC 60x-style bus master: takes one host request at a time, arbitrates for the bus,
// runs an address tenure (with ARTRY retry up to MAX_RETRY), then a single-beat or BEATS-beat
// data tenure, and reports DONE/ERR for one cycle.
// Ports:
//   CLK, RST    : clock, synchronous active-high reset
//   bus         : host handshake and bus control (ppc_bus_master_if.master)
//   A, TT, TSIZ : tristate address-tenure outputs, driven only in ADDR/AWAIT
//   D           : bidirectional data bus, driven only during write data beats
module ppc_bus_master #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned BEATS     = 4,
  parameter int unsigned MAX_RETRY = 15
) (
  input  logic                CLK,
  input  logic                RST,
  ppc_bus_master_if.master    bus,
  output wire  [ADDR_W-1:0]   A,
  output wire  [4:0]          TT,
  output wire  [2:0]          TSIZ,
  inout  wire  [DATA_W-1:0]   D
);

  localparam int unsigned BeatW  = $clog2(BEATS);
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [BeatW-1:0]  LastBeat   = BeatW'(BEATS - 1);
  localparam logic [RetryW-1:0] RetryLimit = RetryW'(MAX_RETRY);

  localparam logic [4:0] TtWrite    = 5'b00010;
  localparam logic [4:0] TtRead     = 5'b01010;
  localparam logic [2:0] TsizBurst  = 3'b010;
  localparam logic [2:0] TsizSingle = 3'b000;

  typedef enum logic [2:0] {
    StIdle, StArb, StAddr, StAwait, StArtw, StDwait, StData, StFin
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic              write_q, burst_q, ci_q, wt_q, gbl_q;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q;
  logic              rd_valid_q;

  logic req_take;  // accept host request this cycle
  logic rd_cap;    // capture a read beat from D this cycle
  logic a_oe;      // drive A/TT/TSIZ
  logic d_oe;      // drive D

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      write_q    <= 1'b0;
      burst_q    <= 1'b0;
      ci_q       <= 1'b0;
      wt_q       <= 1'b0;
      gbl_q      <= 1'b0;
      beat_q     <= '0;
      retry_q    <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      retry_q    <= retry_d;
      err_q      <= err_d;
      rd_valid_q <= rd_cap;
      if (rd_cap) begin
        rdata_q <= D;
      end
      if (req_take) begin
        addr_q  <= bus.REQ_ADDR;
        write_q <= bus.REQ_WRITE;
        burst_q <= bus.REQ_BURST;
        ci_q    <= bus.REQ_CI;
        wt_q    <= bus.REQ_WT;
        gbl_q   <= bus.REQ_GBL;
      end
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    retry_d  = retry_q;
    err_d    = err_q;
    req_take = 1'b0;
    rd_cap   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.REQ_VALID) begin
          req_take = 1'b1;
          retry_d  = '0;
          beat_d   = '0;
          err_d    = 1'b0;
          state_d  = StArb;
        end
      end
      StArb: begin
        // A grant during a pending ARTRY window is not usable
        if (!bus.BG_N && bus.ARTRY_N) begin
          state_d = StAddr;
        end
      end
      StAddr: begin
        state_d = StAwait;
      end
      StAwait: begin
        if (!bus.AACK_N) begin
          state_d = StArtw;
        end
      end
      StArtw: begin
        if (!bus.ARTRY_N) begin
          if (retry_q == RetryLimit) begin
            err_d   = 1'b1;
            state_d = StFin;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = StArb;
          end
        end else begin
          state_d = StDwait;
        end
      end
      StDwait: begin
        if (!bus.TEA_N) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else if (!bus.DBG_N) begin
          beat_d  = '0;
          state_d = StData;
        end
      end
      StData: begin
        // TEA wins over a simultaneous TA; that beat is dropped
        if (!bus.TEA_N) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else if (!bus.TA_N) begin
          rd_cap = !write_q;
          if (!burst_q || (beat_q == LastBeat)) begin
            state_d = StFin;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StFin: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode
  always_comb begin
    bus.REQ_READY = 1'b0;
    bus.BR_N      = 1'b1;
    bus.TS_N      = 1'b1;
    bus.TBST_N    = 1'b1;
    bus.CI        = 1'b0;
    bus.WT        = 1'b0;
    bus.GBL       = 1'b0;
    bus.WD_ACK    = 1'b0;
    bus.DONE      = 1'b0;
    bus.ERR       = 1'b0;
    a_oe          = 1'b0;
    d_oe          = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.REQ_READY = 1'b1;
      end
      StArb: begin
        bus.BR_N = 1'b0;
      end
      StAddr, StAwait: begin
        bus.TS_N   = (state_q != StAddr);
        a_oe       = 1'b1;
        bus.TBST_N = !burst_q;
        bus.CI     = ci_q;
        bus.WT     = wt_q;
        bus.GBL    = gbl_q;
      end
      StData: begin
        d_oe       = write_q;
        bus.WD_ACK = write_q && !bus.TA_N && bus.TEA_N;
      end
      StFin: begin
        bus.DONE = 1'b1;
        bus.ERR  = err_q;
      end
      default: begin
      end
    endcase
  end

  assign bus.RDATA    = rdata_q;
  assign bus.RD_VALID = rd_valid_q;

  assign A    = a_oe ? addr_q : {ADDR_W{1'bz}};
  assign TT   = a_oe ? (write_q ? TtWrite : TtRead) : 5'bzzzzz;
  assign TSIZ = a_oe ? (burst_q ? TsizBurst : TsizSingle) : 3'bzzz;
  assign D    = d_oe ? bus.WDATA : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ppc_bus_master.sv
module tb_ppc_bus_master;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned NB = 4;
  localparam int unsigned MR = 2;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  ppc_bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  wire [AW-1:0] A;
  wire [4:0]    TT;
  wire [2:0]    TSIZ;
  wire [DW-1:0] D;
  logic          tb_d_en;
  logic [DW-1:0] tb_d;
  assign D = tb_d_en ? tb_d : {DW{1'bz}};

  ppc_bus_master #(.ADDR_W(AW), .DATA_W(DW), .BEATS(NB), .MAX_RETRY(MR)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .bus  (bus),
    .A    (A),
    .TT   (TT),
    .TSIZ (TSIZ),
    .D    (D)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    bit          write;
    bit          burst;
    bit          ci;
    bit          wt;
    bit          gbl;
    int          n_artry;
    int          tea_beat;
    bit          stall;
    int          exp_tenures;
    int          exp_beats;
    bit          exp_err;
  } vec_t;

  vec_t vecs[6];

  int checks = 0;
  int errors = 0;
  int ts_cnt, ack_cnt, rv_cnt, done_cnt;
  logic [DW-1:0] rq[$];
  logic [DW-1:0] wq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples mid-cycle after the bench has driven this cycle's inputs
  always begin
    @(negedge CLK);
    #2;
    if (bus.TS_N === 1'b0) ts_cnt++;
    if (bus.DONE === 1'b1) done_cnt++;
    if (bus.WD_ACK === 1'b1) begin
      ack_cnt++;
      if (wq.size() == 0) check("wd_ack_unexpected", bus.WD_ACK, 1'b0);
      else begin
        check("d_write_beat", D, wq[0]);
        void'(wq.pop_front());
      end
    end
    if (bus.RD_VALID === 1'b1) begin
      rv_cnt++;
      if (rq.size() == 0) check("rd_valid_unexpected", bus.RD_VALID, 1'b0);
      else check("rdata", bus.RDATA, rq.pop_front());
    end
  end

  // Host presents the next pending write beat after each edge
  always begin
    @(posedge CLK);
    #1;
    bus.WDATA = (wq.size() > 0) ? wq[0] : '0;
  end

  task automatic issue_req(input vec_t v);
    ts_cnt = 0; ack_cnt = 0; rv_cnt = 0; done_cnt = 0;
    if (v.write) for (int b = 0; b < v.exp_beats; b++) wq.push_back({$urandom, $urandom});
    @(negedge CLK);
    check({v.name, ":req_ready_idle"}, bus.REQ_READY, 1'b1);
    bus.REQ_VALID = 1'b1;
    bus.REQ_ADDR  = v.addr;
    bus.REQ_WRITE = v.write;
    bus.REQ_BURST = v.burst;
    bus.REQ_CI    = v.ci;
    bus.REQ_WT    = v.wt;
    bus.REQ_GBL   = v.gbl;
    @(negedge CLK);
    bus.REQ_VALID = 1'b0;
    check({v.name, ":req_ready_busy"}, bus.REQ_READY, 1'b0);
  endtask

  // Address tenures; returns with the DUT in DWAIT, or in FIN when aborted
  task automatic addr_phase(input vec_t v, output bit aborted);
    bit retry;
    aborted = 1'b0;
    for (int att = 0; att < 8; att++) begin
      check({v.name, ":br_n_arb"}, bus.BR_N, 1'b0);
      bus.BG_N = 1'b0;
      @(negedge CLK);
      bus.BG_N = 1'b1;
      check({v.name, ":ts_n_addr"}, bus.TS_N, 1'b0);
      check({v.name, ":br_n_addr"}, bus.BR_N, 1'b1);
      check({v.name, ":a"}, A, v.addr);
      check({v.name, ":tt"}, TT, v.write ? 5'b00010 : 5'b01010);
      check({v.name, ":tsiz"}, TSIZ, v.burst ? 3'b010 : 3'b000);
      check({v.name, ":tbst_n"}, bus.TBST_N, !v.burst);
      check({v.name, ":attr"}, {bus.CI, bus.WT, bus.GBL}, {v.ci, v.wt, v.gbl});
      @(negedge CLK);
      check({v.name, ":ts_n_await"}, bus.TS_N, 1'b1);
      check({v.name, ":a_hold"}, A, v.addr);
      @(negedge CLK);
      bus.AACK_N = 1'b0;
      @(negedge CLK);
      bus.AACK_N = 1'b1;
      check({v.name, ":a_oe_artw"}, dut.a_oe, 1'b0);
      retry = (att < v.n_artry);
      bus.ARTRY_N = !retry;
      @(negedge CLK);
      bus.ARTRY_N = 1'b1;
      if (!retry) break;
      if (bus.DONE === 1'b1) begin
        aborted = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_txn(input vec_t v);
    bit aborted;
    bit tea;
    int nbeats;
    nbeats = v.burst ? NB : 1;
    issue_req(v);
    addr_phase(v, aborted);
    if (!aborted) begin
      check({v.name, ":d_oe_dwait"}, dut.d_oe, 1'b0);
      bus.DBG_N = 1'b0;
      @(negedge CLK);
      bus.DBG_N = 1'b1;
      for (int b = 0; b < nbeats; b++) begin
        if (v.stall && b > 0) begin
          bus.TA_N = 1'b1;
          @(negedge CLK);
        end
        tea = (b == v.tea_beat);
        bus.TA_N  = 1'b0;
        bus.TEA_N = !tea;
        if (!v.write) begin
          tb_d    = {$urandom, $urandom};
          tb_d_en = 1'b1;
          if (!tea) rq.push_back(tb_d);
        end
        check({v.name, ":d_oe_data"}, dut.d_oe, v.write);
        @(negedge CLK);
        bus.TA_N  = 1'b1;
        bus.TEA_N = 1'b1;
        tb_d_en   = 1'b0;
        if (tea) break;
      end
    end
    check({v.name, ":done"}, bus.DONE, 1'b1);
    check({v.name, ":err"}, bus.ERR, v.exp_err);
    check({v.name, ":d_oe_fin"}, dut.d_oe, 1'b0);
    @(negedge CLK);
    check({v.name, ":done_clear"}, {bus.DONE, bus.ERR}, 2'b00);
    check({v.name, ":req_ready_back"}, bus.REQ_READY, 1'b1);
    #3;
    check({v.name, ":tenures"}, ts_cnt, v.exp_tenures);
    check({v.name, ":wd_acks"}, ack_cnt, v.write ? v.exp_beats : 0);
    check({v.name, ":rd_valids"}, rv_cnt, v.write ? 0 : v.exp_beats);
    check({v.name, ":done_pulses"}, done_cnt, 1);
    check({v.name, ":sb_empty"}, rq.size() + wq.size(), 0);
    rq.delete();
    wq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    bit aborted;
    vec_t rv;
    //           name         addr          wr    bst   ci    wt    gbl  artry tea stall ten beats err
    vecs[0] = '{"single_rd", 32'hAAAAAAA8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1, 1'b0, 1, 1, 1'b0};
    vecs[1] = '{"burst_wr",  32'h10000020, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, -1, 1'b1, 1, 4, 1'b0};
    vecs[2] = '{"retry2_rd", 32'h20000040, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, -1, 1'b0, 3, 4, 1'b0};
    vecs[3] = '{"abort_wr",  32'h30000008, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9, -1, 1'b0, 3, 0, 1'b1};
    vecs[4] = '{"tea_rd",    32'h40000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0,  2, 1'b0, 1, 2, 1'b1};
    vecs[5] = '{"single_wr", 32'h50000018, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1, -1, 1'b0, 2, 1, 1'b0};

    RST = 1'b1;
    tb_d_en = 1'b0;
    tb_d = '0;
    bus.REQ_VALID = 1'b0;
    bus.REQ_ADDR = '0;
    bus.REQ_WRITE = 1'b0;
    bus.REQ_BURST = 1'b0;
    bus.REQ_CI = 1'b0;
    bus.REQ_WT = 1'b0;
    bus.REQ_GBL = 1'b0;
    bus.WDATA = '0;
    bus.BG_N = 1'b1;
    bus.AACK_N = 1'b1;
    bus.ARTRY_N = 1'b1;
    bus.DBG_N = 1'b1;
    bus.TA_N = 1'b1;
    bus.TEA_N = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst:bus_ctl", {bus.BR_N, bus.TS_N, bus.TBST_N}, 3'b111);
    check("rst:attr", {bus.CI, bus.WT, bus.GBL}, 3'b000);
    check("rst:req_ready", bus.REQ_READY, 1'b1);
    check("rst:pulses", {bus.WD_ACK, bus.RD_VALID, bus.DONE, bus.ERR}, 4'b0000);
    check("rst:oe", {dut.a_oe, dut.d_oe}, 2'b00);
    RST = 1'b0;

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Reset in the middle of a write data tenure
    rv = '{"rst_data", 32'h60000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1, 1'b0, 1, 0, 1'b0};
    issue_req(rv);
    addr_phase(rv, aborted);
    bus.DBG_N = 1'b0;
    @(negedge CLK);
    bus.DBG_N = 1'b1;
    check("rst_data:d_oe_data", dut.d_oe, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("rst_data:req_ready", bus.REQ_READY, 1'b1);
    check("rst_data:oe", {dut.a_oe, dut.d_oe}, 2'b00);
    check("rst_data:br_n", bus.BR_N, 1'b1);
    check("rst_data:done", {bus.DONE, bus.ERR}, 2'b00);
    @(negedge CLK);
    #3;
    check("rst_data:no_done", done_cnt, 0);
    check("rst_data:no_acks", ack_cnt, 0);

    run_txn(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
